// File: rtl/rf_cmd_ctrl.sv
// Byte-serial command parser between the UART path and the register file:
// 0xAA,addr,data issues a one-cycle write; 0xBB,addr issues a read and returns the data as a TX byte.
module rf_cmd_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int RD_TIMEOUT = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] rx_data_i,
  input  logic             rx_valid_i,
  input  logic [WIDTH-1:0] rd_data_i,
  input  logic             rd_data_vld_i,
  input  logic             tx_ready_i,
  output logic             wr_en_o,
  output logic             rd_en_o,
  output logic [DEPTH-1:0] address_o,
  output logic [WIDTH-1:0] wr_data_o,
  output logic [WIDTH-1:0] tx_data_o,
  output logic             tx_valid_o,
  output logic             cmd_err_o,
  output logic             ovr_err_o,
  output logic             busy_o
);

  localparam int CntW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(RD_TIMEOUT - 1);
  localparam logic [WIDTH-1:0] OpWrite = WIDTH'(8'hAA);
  localparam logic [WIDTH-1:0] OpRead  = WIDTH'(8'hBB);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_SEND
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] timeoutCnt_q;
  logic            wrEn_q;
  logic            rdEn_q;
  logic [DEPTH-1:0] address_q;
  logic [WIDTH-1:0] wrData_q;
  logic [WIDTH-1:0] txData_q;
  logic            txValid_q;
  logic            cmdErr_q;
  logic            ovrErr_q;

  // Strobes and error flags default low every cycle so each is a single-cycle pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      timeoutCnt_q <= '0;
      wrEn_q       <= 1'b0;
      rdEn_q       <= 1'b0;
      address_q    <= '0;
      wrData_q     <= '0;
      txData_q     <= '0;
      txValid_q    <= 1'b0;
      cmdErr_q     <= 1'b0;
      ovrErr_q     <= 1'b0;
    end else begin
      wrEn_q   <= 1'b0;
      rdEn_q   <= 1'b0;
      cmdErr_q <= 1'b0;
      ovrErr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_valid_i) begin
            if (rx_data_i == OpWrite) begin
              state_q <= WR_ADDR;
            end else if (rx_data_i == OpRead) begin
              state_q <= RD_ADDR;
            end else begin
              cmdErr_q <= 1'b1;
            end
          end
        end
        WR_ADDR: begin
          if (rx_valid_i) begin
            address_q <= rx_data_i[DEPTH-1:0];
            state_q   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (rx_valid_i) begin
            wrData_q <= rx_data_i;
            wrEn_q   <= 1'b1;
            state_q  <= IDLE;
          end
        end
        RD_ADDR: begin
          if (rx_valid_i) begin
            address_q    <= rx_data_i[DEPTH-1:0];
            rdEn_q       <= 1'b1;
            timeoutCnt_q <= '0;
            state_q      <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          ovrErr_q <= rx_valid_i;
          // Data arriving on the timeout edge still wins over the timeout.
          if (rd_data_vld_i) begin
            txData_q  <= rd_data_i;
            txValid_q <= 1'b1;
            state_q   <= TX_SEND;
          end else if (timeoutCnt_q == CntLast) begin
            cmdErr_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            timeoutCnt_q <= timeoutCnt_q + 1'b1;
          end
        end
        TX_SEND: begin
          ovrErr_q <= rx_valid_i;
          if (tx_ready_i) begin
            txValid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_en_o    = wrEn_q;
  assign rd_en_o    = rdEn_q;
  assign address_o  = address_q;
  assign wr_data_o  = wrData_q;
  assign tx_data_o  = txData_q;
  assign tx_valid_o = txValid_q;
  assign cmd_err_o  = cmdErr_q;
  assign ovr_err_o  = ovrErr_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// Testbench for rf_cmd_ctrl: directed corner cases followed by random command traffic,
// checked against a command-level model of register contents and response latencies.
module tb_rf_cmd_ctrl;

  localparam int WIDTH      = 8;
  localparam int DEPTH      = 4;
  localparam int RD_TIMEOUT = 8;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [WIDTH-1:0] rx_data_i;
  logic             rx_valid_i;
  logic [WIDTH-1:0] rd_data_i = '0;
  logic             rd_data_vld_i = 1'b0;
  logic             tx_ready_i;
  logic             wr_en_o;
  logic             rd_en_o;
  logic [DEPTH-1:0] address_o;
  logic [WIDTH-1:0] wr_data_o;
  logic [WIDTH-1:0] tx_data_o;
  logic             tx_valid_o;
  logic             cmd_err_o;
  logic             ovr_err_o;
  logic             busy_o;

  rf_cmd_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rd_data_i(rd_data_i), .rd_data_vld_i(rd_data_vld_i), .tx_ready_i(tx_ready_i),
    .wr_en_o(wr_en_o), .rd_en_o(rd_en_o), .address_o(address_o), .wr_data_o(wr_data_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .cmd_err_o(cmd_err_o),
    .ovr_err_o(ovr_err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [WIDTH-1:0] initVal(input int i);
    return WIDTH'(i * 37 + 5);
  endfunction

  // Pulse and strobe bookkeeping, sampled at the rising edge before outputs update.
  int wrEnCnt = 0, rdEnCnt = 0, cmdErrCnt = 0, ovrErrCnt = 0, txRiseCnt = 0, violCnt = 0;
  logic prevWr = 1'b0, prevRd = 1'b0, prevTx = 1'b0;
  always @(posedge clk_i) begin
    if (wr_en_o) wrEnCnt++;
    if (rd_en_o) rdEnCnt++;
    if (cmd_err_o) cmdErrCnt++;
    if (ovr_err_o) ovrErrCnt++;
    if (tx_valid_o && !prevTx) txRiseCnt++;
    if (wr_en_o && rd_en_o) violCnt++;
    if ((wr_en_o && prevWr) || (rd_en_o && prevRd)) violCnt++;
    prevWr = wr_en_o;
    prevRd = rd_en_o;
    prevTx = tx_valid_o;
  end

  // Register file: captures writes, answers a read rfLatency cycles after its strobe (0 = never).
  logic [WIDTH-1:0] rfMem [2**DEPTH];
  logic [DEPTH-1:0] rdAddr = '0;
  int rdPending = 0;
  int rfLatency = 1;
  bit rfInit = 1'b0;
  always @(negedge clk_i) begin
    if (!rfInit) begin
      for (int i = 0; i < 2**DEPTH; i++) rfMem[i] = initVal(i);
      rfInit = 1'b1;
    end
    rd_data_vld_i = 1'b0;
    if (rdPending > 0) begin
      rdPending--;
      if (rdPending == 0) begin
        rd_data_vld_i = 1'b1;
        rd_data_i = rfMem[rdAddr];
      end
    end
    if (wr_en_o) rfMem[address_o] = wr_data_o;
    if (rd_en_o) begin
      rdAddr = address_o;
      rdPending = rfLatency;
    end
  end

  logic [WIDTH-1:0] expMem [2**DEPTH];

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] b);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    @(negedge clk_i);
    rx_valid_i = 1'b0;
    rx_data_i  = WIDTH'($urandom);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_wr_en"}, 32'(wr_en_o), 0);
    checkOutput({tag, "_rd_en"}, 32'(rd_en_o), 0);
    checkOutput({tag, "_address"}, 32'(address_o), 0);
    checkOutput({tag, "_wr_data"}, 32'(wr_data_o), 0);
    checkOutput({tag, "_tx_data"}, 32'(tx_data_o), 0);
    checkOutput({tag, "_tx_valid"}, 32'(tx_valid_o), 0);
    checkOutput({tag, "_cmd_err"}, 32'(cmd_err_o), 0);
    checkOutput({tag, "_ovr_err"}, 32'(ovr_err_o), 0);
    checkOutput({tag, "_busy"}, 32'(busy_o), 0);
  endtask

  task automatic doWrite(input logic [DEPTH-1:0] a, input logic [WIDTH-1:0] d, input int gap);
    int w0, r0, c0, o0;
    logic [WIDTH-1:0] ab;
    w0 = wrEnCnt; r0 = rdEnCnt; c0 = cmdErrCnt; o0 = ovrErrCnt;
    ab = WIDTH'($urandom);
    ab[DEPTH-1:0] = a;
    applyStimulus(8'hAA);
    checkOutput("wr_busy_after_opcode", 32'(busy_o), 1);
    idle(gap);
    applyStimulus(ab);
    idle(gap);
    applyStimulus(d);
    checkOutput("wr_en", 32'(wr_en_o), 1);
    checkOutput("wr_address", 32'(address_o), 32'(a));
    checkOutput("wr_data", 32'(wr_data_o), 32'(d));
    expMem[a] = d;
    @(negedge clk_i);
    checkOutput("wr_en_single", 32'(wr_en_o), 0);
    checkOutput("wr_idle_busy", 32'(busy_o), 0);
    checkOutput("wr_pulse_count", 32'(wrEnCnt - w0), 1);
    checkOutput("wr_no_rd_en", 32'(rdEnCnt - r0), 0);
    checkOutput("wr_no_errors", 32'((cmdErrCnt - c0) + (ovrErrCnt - o0)), 0);
  endtask

  task automatic doRead(input logic [DEPTH-1:0] a, input int lat, input int hold,
                        input bit injectHold, input bit injectAccept, input int gap);
    int w0, r0, c0, o0, t0, n, ovrExp, expWait;
    bit expectTx, unstable;
    logic [WIDTH-1:0] ab;
    w0 = wrEnCnt; r0 = rdEnCnt; c0 = cmdErrCnt; o0 = ovrErrCnt; t0 = txRiseCnt;
    ovrExp = 0;
    unstable = 1'b0;
    rfLatency = lat;
    ab = WIDTH'($urandom);
    ab[DEPTH-1:0] = a;
    applyStimulus(8'hBB);
    idle(gap);
    applyStimulus(ab);
    checkOutput("rd_en", 32'(rd_en_o), 1);
    checkOutput("rd_address", 32'(address_o), 32'(a));
    expectTx = (lat >= 1) && (lat <= RD_TIMEOUT - 1);
    expWait  = expectTx ? lat + 1 : RD_TIMEOUT;
    n = 0;
    for (int i = 0; i < RD_TIMEOUT + 4; i++) begin
      @(negedge clk_i);
      n++;
      if (tx_valid_o || cmd_err_o) break;
    end
    checkOutput("rd_response_cycles", 32'(n), 32'(expWait));
    if (expectTx) begin
      checkOutput("rd_tx_valid", 32'(tx_valid_o), 1);
      checkOutput("rd_tx_data", 32'(tx_data_o), 32'(expMem[a]));
      checkOutput("rd_no_cmd_err", 32'(cmd_err_o), 0);
      tx_ready_i = 1'b0;
      for (int i = 0; i < hold; i++) begin
        if (injectHold && i == 0) begin
          rx_valid_i = 1'b1;
          rx_data_i  = 8'h11;
          @(negedge clk_i);
          rx_valid_i = 1'b0;
          ovrExp++;
          checkOutput("tx_hold_ovr_err", 32'(ovr_err_o), 1);
        end else begin
          @(negedge clk_i);
        end
        if (tx_valid_o !== 1'b1 || tx_data_o !== expMem[a] || busy_o !== 1'b1) unstable = 1'b1;
      end
      checkOutput("tx_hold_unstable", 32'(unstable), 0);
      tx_ready_i = 1'b1;
      if (injectAccept) begin
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h11;
        ovrExp++;
      end
      @(negedge clk_i);
      tx_ready_i = 1'b0;
      rx_valid_i = 1'b0;
      checkOutput("tx_valid_dropped", 32'(tx_valid_o), 0);
      checkOutput("tx_done_busy", 32'(busy_o), 0);
      if (injectAccept) checkOutput("tx_accept_ovr_err", 32'(ovr_err_o), 1);
      @(negedge clk_i);
      checkOutput("rd_cmd_err_count", 32'(cmdErrCnt - c0), 0);
      checkOutput("rd_tx_rise_count", 32'(txRiseCnt - t0), 1);
    end else begin
      checkOutput("to_cmd_err", 32'(cmd_err_o), 1);
      checkOutput("to_busy", 32'(busy_o), 0);
      checkOutput("to_tx_valid", 32'(tx_valid_o), 0);
      @(negedge clk_i);
      checkOutput("to_cmd_err_single", 32'(cmd_err_o), 0);
      idle(3);
      checkOutput("to_cmd_err_count", 32'(cmdErrCnt - c0), 1);
      checkOutput("to_tx_rise_count", 32'(txRiseCnt - t0), 0);
    end
    checkOutput("rd_pulse_count", 32'(rdEnCnt - r0), 1);
    checkOutput("rd_no_wr_en", 32'(wrEnCnt - w0), 0);
    checkOutput("rd_ovr_err_count", 32'(ovrErrCnt - o0), 32'(ovrExp));
  endtask

  task automatic doBadOp(input logic [WIDTH-1:0] op);
    int w0, r0, c0;
    w0 = wrEnCnt; r0 = rdEnCnt; c0 = cmdErrCnt;
    applyStimulus(op);
    checkOutput("badop_cmd_err", 32'(cmd_err_o), 1);
    checkOutput("badop_busy", 32'(busy_o), 0);
    @(negedge clk_i);
    checkOutput("badop_cmd_err_single", 32'(cmd_err_o), 0);
    checkOutput("badop_cmd_err_count", 32'(cmdErrCnt - c0), 1);
    checkOutput("badop_no_strobes", 32'((wrEnCnt - w0) + (rdEnCnt - r0)), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0, sel, lat;
    logic [WIDTH-1:0] op;
    rst_i = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i = '0;
    tx_ready_i = 1'b0;
    for (int i = 0; i < 2**DEPTH; i++) expMem[i] = initVal(i);
    idle(3);
    checkResetState("por");
    rst_i = 1'b0;
    idle(1);

    $display("[TB] directed write / read / errors");
    doWrite(4'd2, 8'h81, 0);
    doWrite(4'd1, 8'h7E, 1);
    doRead(4'd1, 1, 5, 1'b1, 1'b0, 0);
    doRead(4'd0, 0, 0, 1'b0, 1'b0, 0);
    doBadOp(8'h55);
    doRead(4'd2, RD_TIMEOUT - 1, 1, 1'b0, 1'b0, 1);
    doRead(4'd3, RD_TIMEOUT, 0, 1'b0, 1'b0, 0);
    doRead(4'd2, 2, 0, 1'b0, 1'b1, 2);

    $display("[TB] reset during WR_DATA");
    w0 = wrEnCnt;
    applyStimulus(8'hAA);
    applyStimulus(8'h03);
    rst_i = 1'b1;
    rx_valid_i = 1'b1;
    rx_data_i = 8'h99;
    @(negedge clk_i);
    rx_valid_i = 1'b0;
    @(negedge clk_i);
    checkResetState("midreset");
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("midreset_no_wr_en", 32'(wrEnCnt - w0), 0);
    doWrite(4'd3, 8'h5C, 0);
    doRead(4'd3, 1, 0, 1'b0, 1'b0, 0);

    $display("[TB] random command traffic");
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3) begin
        doWrite(DEPTH'($urandom), WIDTH'($urandom), $urandom_range(0, 3));
      end else if (sel <= 7) begin
        lat = $urandom_range(0, RD_TIMEOUT + 1);
        doRead(DEPTH'($urandom), lat, $urandom_range(0, 3), 1'($urandom), 1'($urandom),
               $urandom_range(0, 3));
      end else if (sel == 8) begin
        do op = WIDTH'($urandom); while (op == 8'hAA || op == 8'hBB);
        doBadOp(op);
      end else begin
        idle($urandom_range(1, 4));
      end
    end

    idle(2);
    checkOutput("strobe_exclusivity", 32'(violCnt), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
